// File: rtl/serial_subtractor_8bit.sv
// Bit-serial A - B - Bin subtractor: one full-subtractor cell and a borrow flop, LSB first.
// Optional signed-overflow flag output when OVF_FLAG_EN is defined.
module serial_subtractor_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic [WIDTH-1:0] r_res, w_res_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             r_borrow, w_borrow_d;
  logic             r_done, w_done_d;
  logic [WIDTH-1:0] r_diff, w_diff_d;
  logic             r_bout, w_bout_d;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_diff_bit;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_res_shift;

`ifdef OVF_FLAG_EN
  // Operand MSBs are kept aside since the operand registers are consumed by the shift.
  logic r_a_msb, w_a_msb_d;
  logic r_b_msb, w_b_msb_d;
  logic r_ovf, w_ovf_d;
`endif

  // Full-subtractor cell on the current LSBs
  always_comb begin
    w_a_bit      = r_a[0];
    w_b_bit      = r_b[0];
    w_diff_bit   = w_a_bit ^ w_b_bit ^ r_borrow;
    w_borrow_nxt = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);
    w_res_shift  = {w_diff_bit, r_res[WIDTH-1:1]};
  end

  always_comb begin
    w_state_d  = r_state;
    w_a_d      = r_a;
    w_b_d      = r_b;
    w_res_d    = r_res;
    w_cnt_d    = r_cnt;
    w_borrow_d = r_borrow;
    w_done_d   = 1'b0;
    w_diff_d   = r_diff;
    w_bout_d   = r_bout;
`ifdef OVF_FLAG_EN
    w_a_msb_d  = r_a_msb;
    w_b_msb_d  = r_b_msb;
    w_ovf_d    = r_ovf;
`endif

    case (r_state)
      StIdle: begin
        if (start) begin
          w_a_d      = A;
          w_b_d      = B;
          w_res_d    = '0;
          w_cnt_d    = '0;
          w_borrow_d = Bin;
`ifdef OVF_FLAG_EN
          w_a_msb_d  = A[WIDTH-1];
          w_b_msb_d  = B[WIDTH-1];
`endif
          w_state_d  = StRun;
        end
      end

      StRun: begin
        w_a_d      = {1'b0, r_a[WIDTH-1:1]};
        w_b_d      = {1'b0, r_b[WIDTH-1:1]};
        w_res_d    = w_res_shift;
        w_borrow_d = w_borrow_nxt;
        w_cnt_d    = r_cnt + 1'b1;
        if (r_cnt == LastBit) begin
          w_diff_d  = w_res_shift;
          w_bout_d  = w_borrow_nxt;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
`ifdef OVF_FLAG_EN
          // w_diff_bit is the result MSB on the final bit
          w_ovf_d   = (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_diff_bit);
`endif
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_a      <= w_a_d;
      r_b      <= w_b_d;
      r_res    <= w_res_d;
      r_cnt    <= w_cnt_d;
      r_borrow <= w_borrow_d;
      r_done   <= w_done_d;
      r_diff   <= w_diff_d;
      r_bout   <= w_bout_d;
    end
  end

`ifdef OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_a_msb <= w_a_msb_d;
      r_b_msb <= w_b_msb_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = (r_state == StRun);
  assign done = r_done;
  assign Diff = r_diff;
  assign Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit: directed cases plus randomized operations
// against an integer-arithmetic reference model.
module tb_serial_subtractor_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B;
  logic       Bin;
  logic       busy, done, Bout;
  logic [7:0] Diff;
`ifdef OVF_FLAG_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor_8bit #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .Diff (Diff),
    .Bout (Bout)
`ifdef OVF_FLAG_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer subtraction, unsigned for Diff/Bout, signed range for ovf
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output logic ov);
    int u;
    int s;
    u  = int'(a) - int'(b) - int'(bin);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = u[7:0];
    bo = (u < 0);
    ov = (s < -128) || (s > 127);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
    A     = a;
    B     = b;
    Bin   = bin;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input string tag);
    int lat;
    lat = n0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 20);
    check({tag, "_latency"}, lat, 8);
    check({tag, "_busy_off"}, busy, 0);
  endtask

  task automatic check_result(input logic [7:0] a, input logic [7:0] b, input logic bin,
                              input string tag);
    logic [7:0] d;
    logic       bo;
    logic       ov;
    model(a, b, bin, d, bo, ov);
    check({tag, "_diff"}, Diff, d);
    check({tag, "_bout"}, Bout, bo);
`ifdef OVF_FLAG_EN
    check({tag, "_ovf"}, ovf, ov);
`endif
  endtask

  initial begin
    int done_seen;
    logic [7:0] ra, rb;
    logic rbin;

    rst   = 1'b1;
    start = 1'b1;  // reset must win over start
    A     = 8'hAA;
    B     = 8'h55;
    Bin   = 1'b1;
    tick();
    tick();
    start = 1'b0;
    rst   = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", Diff, 0);
    check("rst_bout", Bout, 0);
`ifdef OVF_FLAG_EN
    check("rst_ovf", ovf, 0);
`endif
    tick();
    check("idle_busy", busy, 0);

    // 1: basic operation
    start_op(8'h35, 8'h12, 1'b0);
    check("t1_busy_on", busy, 1);
    wait_done(0, "t1");
    check("t1_diff", Diff, 8'h23);
    check("t1_bout", Bout, 0);
    tick();
    check("t1_done_pulse", done, 0);

    // 2: borrow cases
    start_op(8'h00, 8'h01, 1'b0);
    wait_done(0, "t2a");
    check("t2a_diff", Diff, 8'hFF);
    check("t2a_bout", Bout, 1);
    tick();
    start_op(8'h10, 8'h0F, 1'b1);
    wait_done(0, "t2b");
    check("t2b_diff", Diff, 8'h00);
    check("t2b_bout", Bout, 0);
    tick();
    start_op(8'h5A, 8'h5A, 1'b1);
    wait_done(0, "t2c");
    check("t2c_diff", Diff, 8'hFF);
    check("t2c_bout", Bout, 1);
    tick();

    // 3: start while busy ignored; Diff holds previous result during run
    start_op(8'h50, 8'h20, 1'b0);
    tick();
    check("t3_hold_diff", Diff, 8'hFF);
    A     = 8'hFF;
    B     = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_hold_bout", Bout, 1);
    wait_done(2, "t3");
    check("t3_diff", Diff, 8'h30);
    check("t3_bout", Bout, 0);

    // 4: start accepted in the done cycle
    start_op(8'h07, 8'h09, 1'b0);
    wait_done(0, "t4");
    check("t4_diff", Diff, 8'hFE);
    check("t4_bout", Bout, 1);
    tick();

    // 5: reset mid-run aborts with no done pulse
    start_op(8'h44, 8'h11, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_diff", Diff, 0);
    check("t5_bout", Bout, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("t5_no_done", done_seen, 0);
    start_op(8'h44, 8'h11, 1'b0);
    wait_done(0, "t5b");
    check("t5b_diff", Diff, 8'h33);
    tick();

`ifdef OVF_FLAG_EN
    // 6: signed overflow flag
    start_op(8'h80, 8'h01, 1'b0);
    wait_done(0, "t6a");
    check("t6a_diff", Diff, 8'h7F);
    check("t6a_ovf", ovf, 1);
    tick();
    start_op(8'h05, 8'h03, 1'b0);
    wait_done(0, "t6b");
    check("t6b_ovf", ovf, 0);
    tick();
`endif

    // Randomized operations with random idle gaps
    for (int n = 0; n < 40; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      if (n == 0) begin ra = 8'h00; rb = 8'hFF; rbin = 1'b1; end
      if (n == 1) begin ra = 8'hFF; rb = 8'h00; rbin = 1'b0; end
      start_op(ra, rb, rbin);
      wait_done(0, "rnd");
      check_result(ra, rb, rbin, "rnd");
      tick();
      check("rnd_done_pulse", done, 0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
